// File: rtl/gray_code_decoder.sv
// Two-stage Gray-to-binary decoder for the Gray-coded counter bus.
// Flags samples that are not an adjacent step and keeps a saturating error count.
module gray_code_decoder #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err,
  output logic             dir_down,
  output logic [ERR_W-1:0] err_count
);

  // state   | meaning
  // S_EMPTY | no reference sample yet; next valid sample is accepted as-is
  // S_TRACK | reference held in r_prev_bin; each valid sample checked against it
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_TRACK = 1'b1;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic             r_v1;
  logic [WIDTH-1:0] r_g_q;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_prev_bin;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_bin_out;
  logic             r_step_err;
  logic             r_dir_down;
  logic [ERR_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_bin;
  logic             w_up;
  logic             w_dn;
  logic             w_hold;
  logic             w_err;

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(r_g_q >> i);
    end
  end

  assign w_up   = (w_bin == r_prev_bin + ONE);
  assign w_dn   = (w_bin == r_prev_bin - ONE);
  assign w_hold = (w_bin == r_prev_bin);
  assign w_err  = (r_state == S_TRACK) && !w_up && !w_dn && !w_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_g_q       <= '0;
      r_state     <= S_EMPTY;
      r_prev_bin  <= '0;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
      r_step_err  <= 1'b0;
      r_dir_down  <= 1'b0;
    end else begin
      r_v1        <= in_valid;
      r_out_valid <= r_v1;
      if (in_valid) begin
        r_g_q <= gray_in;
      end
      if (r_v1) begin
        r_bin_out  <= w_bin;
        r_prev_bin <= w_bin;
        r_step_err <= w_err;
        r_state    <= S_TRACK;
        if (r_state == S_EMPTY) begin
          r_dir_down <= 1'b0;
        end else if (w_up) begin
          r_dir_down <= 1'b0;
        end else if (w_dn) begin
          r_dir_down <= 1'b1;
        end
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (r_v1 && w_err && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin_out;
  assign step_err  = r_step_err;
  assign dir_down  = r_dir_down;
  assign err_count = r_err_count;

endmodule

// File: doc/gray_code_decoder.md
# gray_code_decoder

Pipelined Gray-to-binary decoder with stream integrity checking. Sits on the receiving side of the Gray-coded counter bus. Accepts a Gray code word per valid cycle and returns its binary value two cycles later. Flags samples that are not an adjacent step (±1, modulo 2^WIDTH) from the previous sample, reports count direction, and keeps a saturating error count.

## Interface
- WIDTH, 8, Gray/binary word width (≥2)
- ERR_W, 8, error counter width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  gray_in carries a sample this cycle
- gray_in  input  WIDTH  Gray-coded word
- err_clr  input  1  synchronous clear of err_count
- out_valid  output  1  bin_out/step_err/dir_down valid this cycle
- bin_out  output  WIDTH  decoded binary value
- step_err  output  1  sample not adjacent to previous valid sample
- dir_down  output  1  last adjacent step was a decrement
- err_count  output  ERR_W  saturating count of step_err events

## Operation
- Stage 1: when in_valid=1, register gray_in into g_q; v1 <= in_valid every cycle. No backpressure; every valid sample is accepted.
- Stage 2: b = prefix XOR of g_q: b[WIDTH-1]=g_q[WIDTH-1], b[i]=b[i+1]^g_q[i]. When v1=1, register bin_out<=b, compute checks, set prev_bin<=b. out_valid <= v1 every cycle.
- bin_out, step_err, dir_down hold their values when out_valid=0.
- Reference-tracking FSM, two states:
  - EMPTY (after reset): no previous sample. First sample: step_err=0, dir_down=0, prev_bin<=b, go to TRACK.
  - TRACK: compare b with prev_bin, all arithmetic modulo 2^WIDTH:
    - b==prev_bin+1: step_err=0, dir_down=0.
    - b==prev_bin-1: step_err=0, dir_down=1.
    - b==prev_bin (hold): step_err=0, dir_down unchanged.
    - otherwise: step_err=1, dir_down unchanged.
  - The reference always advances to b, including on error. The next sample is checked against the erroneous value.
  - Stays in TRACK until rst.
- Wrap: prev 2^WIDTH-1 → 0 is an up step. prev 0 → 2^WIDTH-1 is a down step. Neither is an error.
- Bubbles (in_valid=0) do not touch the reference or the FSM. Only valid samples are compared.
- err_count: increments by 1 in the cycle step_err is registered as 1. Saturates at 2^ERR_W-1.
- err_clr=1 sets err_count to 0 on the next edge. If an increment happens in the same cycle, the clear wins and the result is 0.
- err_clr does not affect the pipeline or the FSM.

## Timing
- Latency is 2 cycles. A sample presented with in_valid=1 at edge N appears with out_valid=1 after edge N+2.
- Throughput is one sample per cycle, sustained.
- err_count reflects an error in the same cycle that step_err=1 is visible.
- Reset values (asynchronous, immediate): out_valid=0, bin_out=0, step_err=0, dir_down=0, err_count=0. Internal state: v1=0, g_q=0, prev_bin=0, FSM=EMPTY.
- Reset mid-stream: in-flight samples are discarded and never produce out_valid. The first sample after deassertion is treated as an EMPTY-state sample.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset, then stream Gray(0)…Gray(299) with in_valid=1 continuously:
  - bin_out = 0…255 then 0…43.
  - out_valid rises exactly 2 cycles after in_valid.
  - step_err never 1, dir_down=0, err_count=0.
- Stream Gray(3),2,1,0,255,254:
  - bin_out = 3,2,1,0,255,254.
  - dir_down=0 on the first output, 1 on all later outputs.
  - step_err=0 throughout.
- Stream Gray(10),Gray(12),Gray(13),Gray(13):
  - step_err = 0,1,0,0.
  - err_count: 1 after the second output, and stays 1.
  - dir_down = 0 on all four outputs.
- Stream Gray(5),Gray(6),Gray(7) with 3 idle cycles between samples:
  - out_valid pulses mirror in_valid, delayed 2 cycles.
  - No step_err; bin_out holds 5 and 6 during the gaps.
- Error counter:
  - Drive 300 non-adjacent samples; err_count sticks at 255.
  - Pulse err_clr in the same cycle as a new error; err_count=0 on the next edge.
- Assert rst for 1 cycle while two samples are in flight:
  - All outputs read 0 immediately; no out_valid for the flushed samples.
  - Then send Gray(77): bin_out=77, step_err=0.
